ysyx_25030085_regfile_mp: RTL and testbench
===========================================

# ysyx_25030085_regfile_mp

Parametrised multi-port integer register file for the NPC core: configurable register count, read ports and write ports, a per-port write-back source mux (ALU / memory / PC+4 / immediate), optional same-cycle write-to-read bypass, and a hardware dump engine. The dump engine streams all registers over a valid/ready handshake. It sits between decode (read ports) and write-back (write ports), and feeds the simulation/debug monitor through the dump port.

## Interface
- XLEN, 32, data width
- NREG, 32, register count; power of two, 16 (RV32E) or 32
- NRD, 2, number of read ports (1..4)
- NWR, 1, number of write ports (1..2)
- BYPASS, 1, 1 = a read returns same-cycle write data to the same index
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NRD*log2(NREG)  read indices, port k at slice k
- rd_data  out  NRD*XLEN  read data, port k at slice k
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR*log2(NREG)  destination indices
- wr_sel  in  NWR*2  source: 0 ALU, 1 memory, 2 PC+4, 3 immediate
- wr_alu, wr_mem, wr_pc, wr_imm  in  NWR*XLEN each  candidate sources
- dump_req  in  1  one-cycle pulse that starts a dump
- dump_ready  in  1  consumer accepts the current dump beat
- dump_valid  out  1  dump beat valid
- dump_idx  out  log2(NREG)  index of the current beat
- dump_data  out  XLEN  value of the current beat
- dump_busy  out  1  dump in progress
- dump_done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- Write data per port: sel 0 → wr_alu, 1 → wr_mem, 2 → wr_pc + 4 (modulo 2^XLEN), 3 → wr_imm.
- Writes commit on the rising clk edge when wr_en is high and wr_addr ≠ 0.
- Index 0 is hardwired to zero: writes to it are dropped, and reads return 0 on every path, including bypass.
- Two write ports targeting the same index: the higher port number wins.
- Reads are combinational from the array.
- With BYPASS=1, a read whose index matches an active write (addr ≠ 0) returns that write's data, using the same priority rule. With BYPASS=0, reads return the pre-edge array contents.
- Dump FSM states and transitions:
  - IDLE → LOAD on dump_req.
  - LOAD → SEND: dump_data ← array[dump_idx], dump_valid ← 1.
  - SEND waits on dump_valid & dump_ready. On handshake: if dump_idx = NREG-1 → IDLE with dump_done pulsed; otherwise dump_idx+1 and back to LOAD.
- The dump reads the live array (pre-edge value, no bypass). Writes landing before an index is loaded are visible in that index's beat.
- dump_req while dump_busy is ignored.
- dump_busy is high in LOAD and SEND.

## Timing
- Reset (async assert, sync release): all registers 0, FSM IDLE, dump_valid 0, dump_busy 0, dump_done 0, dump_idx 0, dump_data 0.
- Write latency: visible on read ports 0 cycles after the edge with BYPASS=1 (same cycle via forward), otherwise on the cycle after the edge.
- Dump latency: dump_req edge → dump_busy high next cycle, first dump_valid two cycles after the request edge.
- Each beat costs a minimum of 2 cycles (LOAD + SEND); a full dump takes at least 2*NREG cycles.
- While dump_valid is high and dump_ready is low, dump_idx and dump_data are held stable. dump_valid never drops without a handshake, except on reset.
- Reset mid-dump aborts immediately with no dump_done.
- dump_done rises the cycle after the final handshake and lasts exactly one cycle; dump_busy falls the same cycle.

## Structure
- Package ysyx_25030085_rf_pkg: wb_sel encoding constants (WB_ALU=0, WB_MEM=1, WB_PC4=2, WB_IMM=3), dump FSM state typedef, default XLEN.
- Sub-module ysyx_25030085_rf_dump: the dump FSM, index counter and output registers. It reads the array through a single internal read port.
- The array and write/bypass logic stay in the top module, built with generate loops over NRD/NWR.

## Test plan
- Reset, then write x5 ← ALU 0x1234_5678; the next cycle rd_addr0=5 → 0x1234_5678. All other registers read 0.
- NWR=2, both ports write x7 (port0 0xAAAA_0000, port1 sel=2 pc 0x8000_0000) → x7 = 0x8000_0004. A write to x0 with 0xFFFF_FFFF → x0 reads 0.
- BYPASS=1: write x3 = 0xDEAD_BEEF while reading x3 the same cycle → 0xDEAD_BEEF. With BYPASS=0 the same stimulus returns the old value 0.
- Preload xi = i*0x11, dump_req with dump_ready tied high → 32 beats with idx 0..31 and data i*0x11 (idx 0 → 0). dump_done pulses once, about 64 cycles after the request.
- dump_ready toggling 1-of-3 cycles → data/idx stable during stalls, no beat lost or duplicated. A second dump_req mid-dump is ignored.
- rst_n asserted at beat 10 → dump_valid/busy drop immediately, registers clear, no dump_done.

Source files
------------

// File: rtl/ysyx_25030085_rf_pkg.sv
// Shared definitions for the multi-port register file: write-back source
// encodings, dump engine states and the default data width.
package ysyx_25030085_rf_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_LOAD = 2'd1,
        DUMP_SEND = 2'd2
    } dump_state_e;

endpackage

// File: rtl/ysyx_25030085_rf_dump.sv
// Register dump engine: walks every index, latching one array value per beat
// and offering it on a valid/ready stream.
module ysyx_25030085_rf_dump
    import ysyx_25030085_rf_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dump_req,
    input  logic            dump_ready,
    output logic [AW-1:0]   rd_idx,
    input  logic [XLEN-1:0] rd_val,
    output logic            dump_valid,
    output logic [AW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_busy,
    output logic            dump_done
);

    dump_state_e state_q, state_d;
    logic        handshake;
    logic        last_beat;

    assign handshake = dump_valid & dump_ready;
    assign last_beat = (dump_idx == AW'(NREG - 1));
    assign rd_idx    = dump_idx;
    assign dump_busy = (state_q != DUMP_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            DUMP_IDLE: if (dump_req) state_d = DUMP_LOAD;
            DUMP_LOAD: state_d = DUMP_SEND;
            DUMP_SEND: if (handshake) state_d = last_beat ? DUMP_IDLE : DUMP_LOAD;
            default:   state_d = DUMP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DUMP_IDLE;
            dump_idx   <= '0;
            dump_data  <= '0;
            dump_valid <= 1'b0;
            dump_done  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dump_done <= 1'b0;
            case (state_q)
                DUMP_IDLE: if (dump_req) dump_idx <= '0;
                DUMP_LOAD: begin
                    // Sampled from the live array so earlier writes show up in this beat.
                    dump_data  <= rd_val;
                    dump_valid <= 1'b1;
                end
                DUMP_SEND: if (handshake) begin
                    dump_valid <= 1'b0;
                    if (last_beat) dump_done <= 1'b1;
                    else           dump_idx  <= dump_idx + AW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_25030085_regfile_mp.sv
// Multi-port integer register file with per-port write-back source mux,
// optional write-to-read bypass and a streaming dump engine.
module ysyx_25030085_regfile_mp
    import ysyx_25030085_rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*2-1:0]    wr_sel,
    input  logic [NWR*XLEN-1:0] wr_alu,
    input  logic [NWR*XLEN-1:0] wr_mem,
    input  logic [NWR*XLEN-1:0] wr_pc,
    input  logic [NWR*XLEN-1:0] wr_imm,
    input  logic                dump_req,
    input  logic                dump_ready,
    output logic                dump_valid,
    output logic [AW-1:0]       dump_idx,
    output logic [XLEN-1:0]     dump_data,
    output logic                dump_busy,
    output logic                dump_done
);

    logic [XLEN-1:0]     regs [NREG];
    logic [NWR*XLEN-1:0] wr_data;
    logic [AW-1:0]       dmp_rd_idx;

    for (genvar w = 0; w < NWR; w++) begin : g_wr_mux
        logic [XLEN-1:0] sel_data;
        always_comb begin
            case (wr_sel[w*2 +: 2])
                WB_ALU:  sel_data = wr_alu[w*XLEN +: XLEN];
                WB_MEM:  sel_data = wr_mem[w*XLEN +: XLEN];
                WB_PC4:  sel_data = wr_pc[w*XLEN +: XLEN] + XLEN'(4);
                default: sel_data = wr_imm[w*XLEN +: XLEN];
            endcase
        end
        assign wr_data[w*XLEN +: XLEN] = sel_data;
    end

    // Later ports overwrite earlier ones, so the highest port wins on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] != '0))
                    regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
            end
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd_port
        logic [AW-1:0]   raddr;
        logic [XLEN-1:0] rdat;
        assign raddr = rd_addr[r*AW +: AW];
        always_comb begin
            rdat = regs[raddr];
            if (BYPASS != 0) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en[w] && (wr_addr[w*AW +: AW] == raddr))
                        rdat = wr_data[w*XLEN +: XLEN];
                end
            end
            // x0 masking last so a forwarded write cannot leak through.
            if (raddr == '0) rdat = '0;
        end
        assign rd_data[r*XLEN +: XLEN] = rdat;
    end

    ysyx_25030085_rf_dump #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW)
    ) u_dump (
        .clk        (clk),
        .rst_n      (rst_n),
        .dump_req   (dump_req),
        .dump_ready (dump_ready),
        .rd_idx     (dmp_rd_idx),
        .rd_val     (regs[dmp_rd_idx]),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

endmodule

// File: tb/tb_ysyx_25030085_regfile_mp.sv
// Directed bench for the multi-port register file: a bypassed two-write-port
// instance plus a non-bypassed single-write-port instance driven in parallel.
module tb_ysyx_25030085_regfile_mp;
    import ysyx_25030085_rf_pkg::*;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [63:0] rd_data0;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [3:0]  wr_sel;
    logic [63:0] wr_alu, wr_mem, wr_pc, wr_imm;
    logic        dump_req, dump_ready;
    logic        dump_valid, dump_busy, dump_done;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        d0_valid, d0_busy, d0_done;
    logic [4:0]  d0_idx;
    logic [31:0] d0_data;

    int    checks = 0;
    int    errors = 0;
    int    cyc_cnt = 0;
    int    done_cnt = 0;
    int    done_at = 0;
    int    req_at = 0;
    beat_t exp_q[$];

    ysyx_25030085_regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel),
        .wr_alu(wr_alu), .wr_mem(wr_mem), .wr_pc(wr_pc), .wr_imm(wr_imm),
        .dump_req(dump_req), .dump_ready(dump_ready), .dump_valid(dump_valid),
        .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy),
        .dump_done(dump_done)
    );

    ysyx_25030085_regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(1), .BYPASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data0),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[4:0]), .wr_sel(wr_sel[1:0]),
        .wr_alu(wr_alu[31:0]), .wr_mem(wr_mem[31:0]), .wr_pc(wr_pc[31:0]),
        .wr_imm(wr_imm[31:0]),
        .dump_req(1'b0), .dump_ready(1'b0), .dump_valid(d0_valid),
        .dump_idx(d0_idx), .dump_data(d0_data), .dump_busy(d0_busy),
        .dump_done(d0_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard side of the dump stream; runs just before each rising edge.
    task automatic mon();
        if (dump_done) begin
            done_cnt++;
            done_at = cyc_cnt;
        end
        if (dump_valid) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL dump_extra: observed beat idx %0d expected no beat", dump_idx);
            end
            if (exp_q.size() > 0) begin
                check("dump_idx", 32'(dump_idx), 32'(exp_q[0].idx));
                check("dump_data", dump_data, exp_q[0].data);
                if (dump_ready) void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic cyc();
        mon();
        @(posedge clk);
        cyc_cnt++;
        @(negedge clk);
    endtask

    task automatic drive_wr(input int p, input logic en, input logic [4:0] a,
                            input logic [1:0] s, input logic [31:0] v);
        wr_en[p]          = en;
        wr_addr[p*5 +: 5] = a;
        wr_sel[p*2 +: 2]  = s;
        wr_alu[p*32 +: 32] = (s == WB_ALU) ? v : ~v;
        wr_mem[p*32 +: 32] = (s == WB_MEM) ? v : ~v;
        wr_pc[p*32 +: 32]  = (s == WB_PC4) ? v : ~v;
        wr_imm[p*32 +: 32] = (s == WB_IMM) ? v : ~v;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        rd_addr[p*5 +: 5] = a;
    endtask

    task automatic push_dump();
        beat_t b;
        for (int i = 0; i < 32; i++) begin
            b.idx  = 5'(i);
            b.data = 32'(i * 32'h11);
            exp_q.push_back(b);
        end
    endtask

    initial begin
        logic found;
        rst_n = 1'b0;
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_sel = '0;
        wr_alu = '0; wr_mem = '0; wr_pc = '0; wr_imm = '0;
        dump_req = 1'b0; dump_ready = 1'b0;
        @(negedge clk);
        cyc(); cyc();
        check("rst_valid", 32'(dump_valid), 32'd0);
        check("rst_busy", 32'(dump_busy), 32'd0);
        check("rst_done", 32'(dump_done), 32'd0);
        check("rst_idx", 32'(dump_idx), 32'd0);
        check("rst_data", dump_data, 32'd0);
        rst_n = 1'b1;
        rd(0, 5'd5); rd(1, 5'd6); #1;
        check("rst_x5", rd_data[31:0], 32'd0);
        cyc();

        // Single write via ALU, bypassed on dut only
        drive_wr(0, 1'b1, 5'd5, WB_ALU, 32'h1234_5678); rd(0, 5'd5); #1;
        check("byp_x5", rd_data[31:0], 32'h1234_5678);
        check("nobyp_x5", rd_data0[31:0], 32'h0);
        cyc(); wr_en = '0; #1;
        check("x5_after", rd_data[31:0], 32'h1234_5678);
        check("x5_after_nb", rd_data0[31:0], 32'h1234_5678);
        check("x6_zero", rd_data[63:32], 32'h0);

        drive_wr(0, 1'b1, 5'd3, WB_IMM, 32'hDEAD_BEEF); rd(1, 5'd3); #1;
        check("byp_x3", rd_data[63:32], 32'hDEAD_BEEF);
        check("nobyp_x3", rd_data0[63:32], 32'h0);
        cyc(); wr_en = '0; #1;
        check("x3_after_nb", rd_data0[63:32], 32'hDEAD_BEEF);

        // Both ports hit x7: port 1 (PC+4) wins
        drive_wr(0, 1'b1, 5'd7, WB_ALU, 32'hAAAA_0000);
        drive_wr(1, 1'b1, 5'd7, WB_PC4, 32'h8000_0000);
        rd(0, 5'd7); #1;
        check("byp_x7_prio", rd_data[31:0], 32'h8000_0004);
        cyc(); wr_en = '0; #1;
        check("x7_prio", rd_data[31:0], 32'h8000_0004);
        check("x7_nb", rd_data0[31:0], 32'hAAAA_0000);

        drive_wr(0, 1'b1, 5'd0, WB_ALU, 32'hFFFF_FFFF);
        drive_wr(1, 1'b1, 5'd0, WB_IMM, 32'hFFFF_FFFF);
        rd(0, 5'd0); #1;
        check("byp_x0", rd_data[31:0], 32'h0);
        cyc(); wr_en = '0; #1;
        check("x0_after", rd_data[31:0], 32'h0);
        check("x0_after_nb", rd_data0[31:0], 32'h0);

        drive_wr(0, 1'b1, 5'd10, WB_PC4, 32'hFFFF_FFFE);
        drive_wr(1, 1'b1, 5'd9, WB_MEM, 32'h0BAD_F00D);
        rd(0, 5'd10); rd(1, 5'd9); #1;
        check("byp_x9_mem", rd_data[63:32], 32'h0BAD_F00D);
        cyc(); wr_en = '0; #1;
        check("x10_pc_wrap", rd_data[31:0], 32'h0000_0002);
        check("x9_mem", rd_data[63:32], 32'h0BAD_F00D);

        // Preload xi = i*0x11
        for (int i = 1; i < 32; i++) begin
            drive_wr(0, 1'b1, 5'(i), WB_ALU, 32'(i * 32'h11));
            cyc();
        end
        wr_en = '0;
        rd(0, 5'd31); rd(1, 5'd1); #1;
        check("x31_pre", rd_data[31:0], 32'h0000_020F);
        check("x1_pre_nb", rd_data0[63:32], 32'h0000_0011);

        // Full-rate dump
        push_dump(); done_cnt = 0;
        dump_ready = 1'b1; dump_req = 1'b1;
        cyc(); dump_req = 1'b0; req_at = cyc_cnt;
        check("dump_busy_1", 32'(dump_busy), 32'd1);
        check("dump_valid_1", 32'(dump_valid), 32'd0);
        cyc();
        check("dump_valid_2", 32'(dump_valid), 32'd1);
        for (int k = 0; k < 200 && done_cnt == 0; k++) cyc();
        check("dump_done_lat", 32'(done_at - req_at), 32'd64);
        check("dump_busy_end", 32'(dump_busy), 32'd0);
        cyc(); cyc();
        check("dump_done_cnt", 32'(done_cnt), 32'd1);
        check("dump_q_empty", 32'(exp_q.size()), 32'd0);

        // Stalled dump with a redundant request in the middle
        push_dump(); done_cnt = 0;
        dump_ready = 1'b0; dump_req = 1'b1;
        cyc(); dump_req = 1'b0;
        for (int k = 0; k < 400 && done_cnt == 0; k++) begin
            dump_ready = ((k % 3) == 2);
            dump_req   = (k == 20);
            cyc();
        end
        dump_req = 1'b0; dump_ready = 1'b1;
        cyc(); cyc(); cyc();
        check("stall_done_cnt", 32'(done_cnt), 32'd1);
        check("stall_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of beat 10
        push_dump(); done_cnt = 0; found = 1'b0;
        dump_req = 1'b1;
        cyc(); dump_req = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (dump_valid && dump_idx == 5'd10) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        check("beat10_reached", 32'(found), 32'd1);
        exp_q.delete();
        rst_n = 1'b0; #1;
        check("abort_valid", 32'(dump_valid), 32'd0);
        check("abort_busy", 32'(dump_busy), 32'd0);
        rd(0, 5'd5); rd(1, 5'd31); #1;
        check("abort_x5", rd_data[31:0], 32'd0);
        check("abort_x31", rd_data[63:32], 32'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc(); cyc(); cyc();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_idle", 32'(dump_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
